// File: rtl/imm_gen_pipe_pkg.sv
// Shared formats, opcodes and skid-buffer states for the immediate generator.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_ARITH_IMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC      = 7'b0010111;
  localparam logic [6:0] OP_STORE      = 7'b0100011;
  localparam logic [6:0] OP_ARITH      = 7'b0110011;
  localparam logic [6:0] OP_LUI        = 7'b0110111;
  localparam logic [6:0] OP_BRANCH     = 7'b1100011;
  localparam logic [6:0] OP_JALR       = 7'b1100111;
  localparam logic [6:0] OP_JAL        = 7'b1101111;
  localparam logic [6:0] OP_ECALL      = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instruction + pc -> sign-extended imm, format, illegal flag, pc-relative target.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ENABLE_U     = 1'b1,
  parameter bit ENABLE_PCREL = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal,
  output logic [XLEN-1:0] target
);

  // Every format fits a signed 32-bit value; widening to XLEN is one sign-extending cast.
  logic signed [31:0] raw;
  logic               pcrel;

  always_comb begin
    raw     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    pcrel   = 1'b0;
    case (inst[6:0])
      OP_ARITH_IMM, OP_LOAD, OP_JALR, OP_ECALL: begin
        fmt = FMT_I;
        raw = 32'($signed(inst[31:20]));
      end
      OP_STORE: begin
        fmt = FMT_S;
        raw = 32'($signed({inst[31:25], inst[11:7]}));
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        raw   = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        pcrel = 1'b1;
      end
      OP_JAL: begin
        fmt   = FMT_J;
        raw   = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        pcrel = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        if (ENABLE_U) begin
          fmt   = FMT_U;
          raw   = {inst[31:12], 12'b0};
          pcrel = (inst[6:0] == OP_AUIPC);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ARITH: fmt = FMT_R;
      default:  illegal = 1'b1;
    endcase
  end

  assign imm    = XLEN'(raw);
  assign target = (ENABLE_PCREL && pcrel) ? (pc + imm) : '0;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator stage with a 2-entry skid buffer between fetch and execute.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  ST_EMPTY | nothing buffered; out_valid=0, in_ready=1
//  ST_ONE   | main register holds the head entry; in_ready=1
//  ST_FULL  | main + skid both occupied; in_ready=0
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ENABLE_U     = 1'b1,
  parameter bit ENABLE_PCREL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  entry_t      dec;
  entry_t      main_q;
  entry_t      skid_q;
  skid_state_e state;
  logic        accept;
  logic        consume;

  imm_decode #(
    .XLEN         (XLEN),
    .ENABLE_U     (ENABLE_U),
    .ENABLE_PCREL (ENABLE_PCREL)
  ) u_decode (
    .inst    (in_inst),
    .pc      (in_pc),
    .imm     (dec.imm),
    .fmt     (dec.fmt),
    .illegal (dec.illegal),
    .target  (dec.target)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; out_valid=0 qualifies them.
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q    <= dec;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q   <= dec;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (consume) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_q   <= skid_q;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_target  = main_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: default config plus XLEN=64 and ENABLE_U=0 instances on shared inputs.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic [31:0] target;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'h0, in_pc};

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_target;
  logic [2:0]  out_fmt;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [63:0] w_out_imm, w_out_target;
  logic [2:0]  w_out_fmt;

  logic        nu_in_ready, nu_out_valid, nu_out_illegal;
  logic [31:0] nu_out_imm, nu_out_target;
  logic [2:0]  nu_out_fmt;

  imm_gen_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_target(out_target)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_target(w_out_target)
  );

  imm_gen_pipe #(.ENABLE_U(1'b0)) dutnu (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nu_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(nu_out_valid), .out_ready(out_ready),
    .out_imm(nu_out_imm), .out_fmt(nu_out_fmt), .out_illegal(nu_out_illegal), .out_target(nu_out_target)
  );

  exp_t sb[$];
  exp_t mon_exp;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic exp_t mk(input logic [31:0] imm, input logic [2:0] fmt,
                              input logic ill, input logic [31:0] tgt);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.illegal = ill; e.target = tgt;
    return e;
  endfunction

  // Output monitor: every consumed entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_extra: got imm=%h fmt=%0d ill=%b tgt=%h, required no output",
                 out_imm, out_fmt, out_illegal, out_target);
      end else begin
        mon_exp = sb.pop_front();
        if ({out_imm, out_fmt, out_illegal, out_target} !== mon_exp) begin
          tests_failed++;
          $display("FAIL sb_out: got imm=%h fmt=%0d ill=%b tgt=%h, required imm=%h fmt=%0d ill=%b tgt=%h",
                   out_imm, out_fmt, out_illegal, out_target,
                   mon_exp.imm, mon_exp.fmt, mon_exp.illegal, mon_exp.target);
        end
      end
    end
  end

  task automatic send(input logic [31:0] inst, input exp_t e);
    in_inst  = inst;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries outstanding, required 0", sb.size());
    end
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h100;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_target} !==
        {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b r=%b imm=%h fmt=%0d ill=%b tgt=%h, required v=0 r=1 rest 0",
               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_target);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_i_s();
    out_ready = 1'b1; in_pc = 32'h100;
    send(32'hFFF00093, mk(32'hFFFFFFFF, FMT_I, 1'b0, 32'h0));
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_i: out_valid=%b one cycle after accept, required 1", out_valid);
    end
    @(posedge clk); #1;
    send(32'hFE20AE23, mk(32'hFFFFFFFC, FMT_S, 1'b0, 32'h0));
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_s: out_valid=%b one cycle after accept, required 1", out_valid);
    end
    drain();
  endtask

  task automatic test_b_j();
    out_ready = 1'b1; in_pc = 32'h100;
    send(32'hFE000CE3, mk(32'hFFFFFFF8, FMT_B, 1'b0, 32'h000000F8));
    send(32'h001000EF, mk(32'h00000800, FMT_J, 1'b0, 32'h00000900));
    in_pc = 32'hFFFFFFF0;
    send(32'h001000EF, mk(32'h00000800, FMT_J, 1'b0, 32'h000007F0));
    in_pc = 32'h100;
    drain();
  endtask

  task automatic test_u_width();
    out_ready = 1'b1; in_pc = 32'h100;
    send(32'h123452B7, mk(32'h12345000, FMT_U, 1'b0, 32'h0));
    @(negedge clk);
    tests_run++;
    if ({nu_out_valid, nu_out_illegal, nu_out_fmt, nu_out_imm} !== {1'b1, 1'b1, 3'd0, 32'h0}) begin
      tests_failed++;
      $display("FAIL u_disabled: got v=%b ill=%b fmt=%0d imm=%h, required v=1 ill=1 fmt=0 imm=0",
               nu_out_valid, nu_out_illegal, nu_out_fmt, nu_out_imm);
    end
    tests_run++;
    if (w_out_imm !== 64'h0000000012345000) begin
      tests_failed++;
      $display("FAIL w64_lui_pos: got %h, required 0000000012345000", w_out_imm);
    end
    @(posedge clk); #1;
    send(32'h80000537, mk(32'h80000000, FMT_U, 1'b0, 32'h0));
    @(negedge clk);
    tests_run++;
    if ({w_out_imm, w_out_fmt} !== {64'hFFFFFFFF80000000, 3'd4}) begin
      tests_failed++;
      $display("FAIL w64_lui_neg: got imm=%h fmt=%0d, required imm=ffffffff80000000 fmt=4",
               w_out_imm, w_out_fmt);
    end
    @(posedge clk); #1;
    send(32'h00001297, mk(32'h00001000, FMT_U, 1'b0, 32'h00001100));
    @(negedge clk);
    tests_run++;
    if ({nu_out_illegal, nu_out_target, w_out_target} !== {1'b1, 32'h0, 64'h1100}) begin
      tests_failed++;
      $display("FAIL auipc_variants: got nu_ill=%b nu_tgt=%h w_tgt=%h, required 1 0 1100",
               nu_out_illegal, nu_out_target, w_out_target);
    end
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_pc = 32'h100;
    send(32'hFFFFFFFF, mk(32'h0, FMT_NONE, 1'b1, 32'h0));
    send(32'h002081B3, mk(32'h0, FMT_R, 1'b0, 32'h0));
    send(32'hFFC08067, mk(32'hFFFFFFFC, FMT_I, 1'b0, 32'h0));
    send(32'h00000073, mk(32'h0, FMT_I, 1'b0, 32'h0));
    drain();
  endtask

  task automatic test_backpressure();
    int idx;
    bit took;
    out_ready = 1'b0; in_pc = 32'h100; idx = 0;
    in_inst = {12'(idx + 1), 13'h0, 7'h13};
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && (idx < 4 || sb.size() != 0); cyc++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sb.push_back(mk(32'(idx + 1), FMT_I, 1'b0, 32'h0));
      if (cyc == 2 || cyc == 3) begin
        tests_run++;
        if ({in_ready, out_valid, out_imm} !== {1'b0, 1'b1, 32'h1}) begin
          tests_failed++;
          $display("FAIL bp_full_stall: cyc=%0d got r=%b v=%b imm=%h, required r=0 v=1 imm=1",
                   cyc, in_ready, out_valid, out_imm);
        end
      end
      if (cyc >= 4) begin
        tests_run++;
        if (out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_gap: cyc=%0d out_valid=%b, required 1", cyc, out_valid);
        end
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 4) in_inst = {12'(idx + 1), 13'h0, 7'h13};
        else in_valid = 1'b0;
      end
      if (cyc == 3) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    tests_run++;
    if (idx != 4 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_complete: accepted=%0d outstanding=%0d, required 4 and 0", idx, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_pc = 32'h100;
    send(32'h01100093, mk(32'h11, FMT_I, 1'b0, 32'h0));
    send(32'h02200093, mk(32'h22, FMT_I, 1'b0, 32'h0));
    in_inst = 32'h0EE00093; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_pre_full: in_ready=%b, required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_full: got v=%b r=%b, required v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h03300093, mk(32'h33, FMT_I, 1'b0, 32'h0));
    in_inst = 32'h0DD00093; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if ({out_valid, in_ready} !== 2'b01) begin
        tests_failed++;
        $display("FAIL flush_one_accept: got v=%b r=%b imm=%h, required v=0 r=1", out_valid, in_ready, out_imm);
      end
    end
    @(posedge clk); #1;
    send(32'h04400093, mk(32'h44, FMT_I, 1'b0, 32'h0));
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_pc = 32'h100;
    send(32'h001000EF, mk(32'h800, FMT_J, 1'b0, 32'h900));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; sb.delete();
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_target} !==
        {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid: got v=%b r=%b imm=%h fmt=%0d ill=%b tgt=%h, required v=0 r=1 rest 0",
               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_target);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hFFFFFFFF, mk(32'h0, FMT_NONE, 1'b1, 32'h0));
    drain();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h100;
    test_reset();
    test_i_s();
    test_b_j();
    test_u_width();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
